// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state definitions for the sequential ALU and its bench.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] OPC_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] OPC_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] OPC_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] OPC_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] OPC_XOR = 3'b100;
  localparam logic [ALU_OP_W-1:0] OPC_SLL = 3'b101;
  localparam logic [ALU_OP_W-1:0] OPC_SRA = 3'b110;
  localparam logic [ALU_OP_W-1:0] OPC_MUL = 3'b111;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = OPC_ADD,
    OP_SUB = OPC_SUB,
    OP_AND = OPC_AND,
    OP_OR  = OPC_OR,
    OP_XOR = OPC_XOR,
    OP_SLL = OPC_SLL,
    OP_SRA = OPC_SRA,
    OP_MUL = OPC_MUL
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle of the sequential ALU; master drives requests, slave returns results.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 11
);
  logic                  start_in;
  logic [ALU_OP_W-1:0]   operation_in;
  logic [DATA_WIDTH-1:0] A_in;
  logic [DATA_WIDTH-1:0] B_in;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  zero_indicator_out;
  logic                  signal_bit_out;
  logic                  carry_out;
  logic                  overflow_out;
  logic                  busy_out;
  logic                  done_out;

  modport master (
    output start_in, operation_in, A_in, B_in,
    input  alu_out, zero_indicator_out, signal_bit_out, carry_out, overflow_out,
           busy_out, done_out
  );

  modport slave (
    input  start_in, operation_in, A_in, B_in,
    output alu_out, zero_indicator_out, signal_bit_out, carry_out, overflow_out,
           busy_out, done_out
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one partial product per step; built only with ALU_SEQ_MUL_EN.
// prod_out is the accumulator value after the current step, so the caller captures it on the last step.
module alu_mul_iter #(
  parameter int DATA_WIDTH = 11
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic                    load_in,
  input  logic                    step_in,
  input  logic [DATA_WIDTH-1:0]   a_in,
  input  logic [DATA_WIDTH-1:0]   b_in,
  output logic                    last_out,
  output logic [2*DATA_WIDTH-1:0] prod_out
);
  localparam int              CW        = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]   LAST_STEP = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]   STEP_ONE  = CW'(1);

  logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [2*DATA_WIDTH-1:0] acc_q, acc_d, acc_nxt;
  logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  always_comb begin
    acc_nxt  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load_in) begin
      mcand_d  = {{DATA_WIDTH{1'b0}}, a_in};
      mplier_d = b_in;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_in) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_nxt;
      cnt_d    = cnt_q + STEP_ONE;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign last_out = step_in && (cnt_q == LAST_STEP);
  assign prod_out = acc_nxt;
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arith/logic/shift ops; MUL iterates DATA_WIDTH steps when ALU_SEQ_MUL_EN
// is defined, otherwise opcode 111 completes in one cycle with overflow set as an illegal-op marker.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 11
) (
  input  logic     clock_in,
  input  logic     reset_in,
  alu_seq_if.slave bus
);
  localparam int                    MSB       = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] SHIFT_LIM = DATA_WIDTH[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH:0]   CARRY_IN  = {{DATA_WIDTH{1'b0}}, 1'b1};

  alu_state_t state_q, state_d;
  alu_op_t    op;
  logic       accept, mul_sel, mul_last, load_alu;

  logic [DATA_WIDTH-1:0]        a, b, ex_res, res_q, res_d;
  logic signed [DATA_WIDTH-1:0] sra_res;
  logic [DATA_WIDTH:0]          sum;
  logic                         ex_c, ex_v, carry_q, carry_d, ovf_q, ovf_d;

  assign op      = alu_op_t'(bus.operation_in);
  assign a       = bus.A_in;
  assign b       = bus.B_in;
  assign accept  = bus.start_in && (state_q != ST_MUL);
  assign sra_res = $signed(a) >>> b;

`ifdef ALU_SEQ_MUL_EN
  logic                    mul_load, mul_step;
  logic [2*DATA_WIDTH-1:0] mul_prod;

  assign mul_sel  = (op == OP_MUL);
  assign mul_load = accept && mul_sel;
  assign mul_step = (state_q == ST_MUL);

  alu_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .load_in  (mul_load),
    .step_in  (mul_step),
    .a_in     (a),
    .b_in     (b),
    .last_out (mul_last),
    .prod_out (mul_prod)
  );
`else
  assign mul_sel  = 1'b0;
  assign mul_last = 1'b0;
`endif

  always_ff @(posedge clock_in) begin
    if (reset_in) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = mul_sel ? ST_MUL : ST_DONE;
        else        state_d = ST_IDLE;
      end
      ST_MUL:  if (mul_last) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy_out = (state_q == ST_MUL);
    bus.done_out = (state_q == ST_DONE);
    load_alu     = accept && !mul_sel;
  end

  always_comb begin
    sum    = '0;
    ex_res = '0;
    ex_c   = 1'b0;
    ex_v   = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        ex_res = sum[MSB:0];
        ex_c   = sum[DATA_WIDTH];
        ex_v   = (a[MSB] == b[MSB]) && (ex_res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + CARRY_IN;
        ex_res = sum[MSB:0];
        ex_c   = sum[DATA_WIDTH];
        ex_v   = (a[MSB] != b[MSB]) && (ex_res[MSB] != a[MSB]);
      end
      OP_AND: ex_res = a & b;
      OP_OR:  ex_res = a | b;
      OP_XOR: ex_res = a ^ b;
      OP_SLL: ex_res = (b >= SHIFT_LIM) ? '0 : (a << b);
      OP_SRA: ex_res = (b >= SHIFT_LIM) ? {DATA_WIDTH{a[MSB]}} : sra_res;
      // Only reaches the result registers when no multiplier is built.
      OP_MUL: ex_v = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (load_alu) begin
      res_d   = ex_res;
      carry_d = ex_c;
      ovf_d   = ex_v;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (mul_last) begin
      res_d   = mul_prod[MSB:0];
      carry_d = 1'b0;
      ovf_d   = |mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
    end
`endif
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.alu_out            = res_q;
  assign bus.zero_indicator_out = (res_q == '0);
  assign bus.signal_bit_out     = res_q[MSB];
  assign bus.carry_out          = carry_q;
  assign bus.overflow_out       = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, multi-cycle corner sequences and a randomized model check.
// Multiplier-specific sequences follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int     DW   = 11;
  localparam longint MASK = (64'sd1 <<< DW) - 1;
  localparam longint HALF = 64'sd1 <<< (DW - 1);
  localparam int     TMO  = 3 * DW + 10;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    bit            c;
    bit            v;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   busy_seen = 1'b0;
  vec_t vecs[$];

  alu_seq_if #(.DATA_WIDTH(DW)) bus ();
  alu_seq #(.DATA_WIDTH(DW)) dut (.clock_in(clk), .reset_in(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.busy_out === 1'b1) busy_seen = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input longint res, input bit c, input bit v);
    chk({tag, "_res"},  64'(bus.alu_out), 64'(res));
    chk({tag, "_zero"}, 64'(bus.zero_indicator_out), 64'(res == 0));
    chk({tag, "_sign"}, 64'(bus.signal_bit_out), 64'((res >> (DW - 1)) & 1));
    chk({tag, "_carry"}, 64'(bus.carry_out), 64'(c));
    chk({tag, "_ovf"},  64'(bus.overflow_out), 64'(v));
  endtask

  // Reference: integer arithmetic on the operand values, signed views taken explicitly.
  function automatic void model(input logic [2:0] op, input longint a, input longint b,
                                output longint res, output bit c, output bit v);
    longint sa, sb, s;
    sa  = (a >= HALF) ? a - 2 * HALF : a;
    sb  = (b >= HALF) ? b - 2 * HALF : b;
    res = 0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = a + b; res = s & MASK; c = s[DW]; v = (sa + sb >= HALF) || (sa + sb < -HALF); end
      3'd1: begin s = a + ((~b) & MASK) + 1; res = s & MASK; c = s[DW]; v = (sa - sb >= HALF) || (sa - sb < -HALF); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = (b >= DW) ? 0 : ((a << b) & MASK);
      3'd6: res = (b >= DW) ? ((sa < 0) ? MASK : 0) : ((sa >>> b) & MASK);
      default: begin
        if (MUL_EN) begin s = a * b; res = s & MASK; v = (s >> DW) != 0; end
        else begin res = 0; v = 1'b1; end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    return (op == OPC_MUL && MUL_EN) ? DW + 1 : 1;
  endfunction

  // lat = negedges from the accepting edge until done_out is seen.
  task automatic do_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    bus.start_in = 1'b1; bus.operation_in = op; bus.A_in = a; bus.B_in = b;
    @(negedge clk);
    bus.start_in = 1'b0; bus.A_in = DW'($urandom); bus.B_in = DW'($urandom);
    lat = 1; busy_cnt = 0;
    while (bus.done_out !== 1'b1 && lat < TMO) begin
      if (bus.busy_out === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int lat, bcnt;
    longint er; bit ec, ev;
    logic [2:0] op;
    logic [DW-1:0] a, b;

    vecs.push_back('{OPC_ADD, 11'h3FF, 11'h001, 11'h400, 1'b0, 1'b1});
    vecs.push_back('{OPC_SUB, 11'h003, 11'h002, 11'h001, 1'b1, 1'b0});
    vecs.push_back('{OPC_SUB, 11'h002, 11'h003, 11'h7FF, 1'b0, 1'b0});
    vecs.push_back('{OPC_SRA, 11'h400, 11'h003, 11'h780, 1'b0, 1'b0});
    vecs.push_back('{OPC_SLL, 11'h001, 11'h00B, 11'h000, 1'b0, 1'b0});
    vecs.push_back('{OPC_AND, 11'h5A5, 11'h0F0, 11'h0A0, 1'b0, 1'b0});
    vecs.push_back('{OPC_OR,  11'h400, 11'h001, 11'h401, 1'b0, 1'b0});
    vecs.push_back('{OPC_XOR, 11'h7FF, 11'h7FF, 11'h000, 1'b0, 1'b0});
    vecs.push_back('{OPC_ADD, 11'h7FF, 11'h001, 11'h000, 1'b1, 1'b0});
    vecs.push_back('{OPC_SUB, 11'h400, 11'h001, 11'h3FF, 1'b1, 1'b1});
    vecs.push_back('{OPC_SRA, 11'h7FF, 11'h014, 11'h7FF, 1'b0, 1'b0});
    vecs.push_back('{OPC_SLL, 11'h003, 11'h00A, 11'h400, 1'b0, 1'b0});
    vecs.push_back('{OPC_SRA, 11'h3FF, 11'h00B, 11'h000, 1'b0, 1'b0});
`ifdef ALU_SEQ_MUL_EN
    vecs.push_back('{OPC_MUL, 11'h019, 11'h028, 11'h3E8, 1'b0, 1'b0});
`else
    vecs.push_back('{OPC_MUL, 11'h019, 11'h028, 11'h000, 1'b0, 1'b1});
`endif
    vecs.push_back('{OPC_MUL, 11'h040, 11'h040, 11'h000, 1'b0, 1'b1});

    rst = 1'b1; bus.start_in = 1'b0; bus.operation_in = '0; bus.A_in = '0; bus.B_in = '0;
    repeat (2) @(negedge clk);
    check_out("reset", 0, 1'b0, 1'b0);
    chk("reset_busy", 64'(bus.busy_out), 0);
    chk("reset_done", 64'(bus.done_out), 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      check_out($sformatf("vec%0d", i), 64'(vecs[i].res), vecs[i].c, vecs[i].v);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].op)));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'((exp_lat(vecs[i].op) > 1) ? DW : 0));
    end

    // Results hold with no pulse while idle.
    repeat (3) @(negedge clk);
    chk("hold_done", 64'(bus.done_out), 0);
    check_out("hold", 64'(vecs[vecs.size()-1].res), vecs[vecs.size()-1].c, vecs[vecs.size()-1].v);

    // Back-to-back single-cycle ops, one accepted per edge.
    @(negedge clk);
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        chk($sformatf("b2b%0d_done", i), 64'(bus.done_out), 1);
        check_out($sformatf("b2b%0d", i), er, ec, ev);
      end
      if (i < 16) begin
        op = 3'($urandom_range(0, 6));
        a  = DW'($urandom);
        b  = (op >= 3'd5) ? DW'($urandom_range(0, DW + 2)) : DW'($urandom);
        bus.start_in = 1'b1; bus.operation_in = op; bus.A_in = a; bus.B_in = b;
        model(op, longint'(a), longint'(b), er, ec, ev);
      end else begin
        bus.start_in = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_end_done", 64'(bus.done_out), 0);

    // Reset wins over a simultaneous start.
    do_op(OPC_ADD, 11'h100, 11'h200, lat, bcnt);
    check_out("pre_rst", 64'h300, 1'b0, 1'b0);
    rst = 1'b1; bus.start_in = 1'b1; bus.operation_in = OPC_ADD; bus.A_in = 11'h001; bus.B_in = 11'h001;
    @(negedge clk);
    rst = 1'b0; bus.start_in = 1'b0;
    check_out("rst_start", 0, 1'b0, 1'b0);
    chk("rst_start_done", 64'(bus.done_out), 0);
    @(negedge clk);
    chk("rst_start_after_done", 64'(bus.done_out), 0);
    chk("rst_start_after_res", 64'(bus.alu_out), 0);

`ifdef ALU_SEQ_MUL_EN
    // New start during MUL is ignored; the original product is returned.
    @(negedge clk);
    bus.start_in = 1'b1; bus.operation_in = OPC_MUL; bus.A_in = 11'd25; bus.B_in = 11'd40;
    @(negedge clk);
    bus.operation_in = OPC_ADD; bus.A_in = 11'd7; bus.B_in = 11'd9;
    lat = 1;
    while (bus.done_out !== 1'b1 && lat < TMO) begin
      if (lat == 4) bus.start_in = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.start_in = 1'b0;
    chk("mul_ignore_latency", 64'(lat), 64'(DW + 1));
    check_out("mul_ignore", 64'h3E8, 1'b0, 1'b0);

    // Reset mid-MUL aborts with no done pulse.
    @(negedge clk);
    bus.start_in = 1'b1; bus.operation_in = OPC_MUL; bus.A_in = 11'd25; bus.B_in = 11'd40;
    @(negedge clk);
    bus.start_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_mul_busy", 64'(bus.busy_out), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mul_abort_busy", 64'(bus.busy_out), 0);
    chk("mul_abort_done", 64'(bus.done_out), 0);
    check_out("mul_abort", 0, 1'b0, 1'b0);
    bcnt = 0;
    for (int i = 0; i < DW + 3; i++) begin
      @(negedge clk);
      if (bus.done_out === 1'b1) bcnt++;
    end
    chk("mul_abort_no_done", 64'(bcnt), 0);
    do_op(OPC_MUL, 11'd3, 11'd5, lat, bcnt);
    check_out("mul_after_abort", 15, 1'b0, 1'b0);
    chk("mul_after_abort_latency", 64'(lat), 64'(DW + 1));
`endif

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = (op == OPC_MUL && $urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 40)) : DW'($urandom);
      b  = (op == OPC_SLL || op == OPC_SRA) ? DW'($urandom_range(0, DW + 3)) : DW'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(op, a, b, lat, bcnt);
      model(op, longint'(a), longint'(b), er, ec, ev);
      check_out($sformatf("rnd%0d_op%0d", i, op), er, ec, ev);
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_lat(op)));
    end

`ifndef ALU_SEQ_MUL_EN
    chk("busy_never_high", 64'(busy_seen), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
